// File: rtl/miriscv_lsu.sv
// miriscv_lsu: load/store unit bridging the pipeline to a req/gnt/rvalid data bus with response timeout
module miriscv_lsu #(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_valid_o,
  output logic        lsu_misalign_o,
  output logic        lsu_bus_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state;
  logic we_q;
  logic [2:0] size_q;
  logic [31:0] addr_q, wdata_q, wdata_n, sh, ld;
  logic [3:0] be_q, be_n;
  logic [15:0] cnt;
  logic legal, half, timeout;
  always_comb begin
    half = lsu_size_i == 3'd1 || lsu_size_i == 3'd3;
    legal = lsu_size_i == 3'd0 ? lsu_addr_i[1:0] == 2'b00 :
            half ? ~lsu_addr_i[0] : (lsu_size_i == 3'd2 || lsu_size_i == 3'd4);
    be_n = lsu_size_i == 3'd0 ? 4'b1111 :
           half ? (lsu_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lsu_addr_i[1:0];
    wdata_n = lsu_size_i == 3'd0 ? lsu_data_i :
              half ? {2{lsu_data_i[15:0]}} : {4{lsu_data_i[7:0]}};
    sh = data_rdata_i >> {addr_q[1:0], 3'b000};
    ld = size_q == 3'd1 ? {{16{sh[15]}}, sh[15:0]} :
         size_q == 3'd2 ? {{24{sh[7]}}, sh[7:0]} :
         size_q == 3'd3 ? {16'b0, sh[15:0]} :
         size_q == 3'd4 ? {24'b0, sh[7:0]} : sh;
    // rvalid arriving on the threshold cycle wins over the timeout
    timeout = state == RESP && !data_rvalid_i && cnt == 16'(RESP_TIMEOUT - 1);
    lsu_misalign_o = state == IDLE && lsu_req_i && !legal;
    lsu_stall_req_o = (state == IDLE && lsu_req_i && legal) || state == REQ ||
                      (state == RESP && !data_rvalid_i && !timeout);
    data_req_o = state == REQ;
    data_we_o = we_q;
    data_be_o = be_q;
    data_addr_o = {addr_q[31:2], 2'b00};
    data_wdata_o = wdata_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      lsu_data_o <= '0;
      lsu_valid_o <= 1'b0;
      lsu_bus_err_o <= 1'b0;
    end else begin
      lsu_valid_o <= state == RESP && data_rvalid_i;
      lsu_bus_err_o <= timeout;
      case (state)
        IDLE: if (lsu_req_i && legal) begin
          state <= REQ;
          we_q <= lsu_we_i;
          size_q <= lsu_size_i;
          addr_q <= lsu_addr_i;
          wdata_q <= wdata_n;
          be_q <= be_n;
        end
        REQ: if (data_gnt_i) begin
          state <= RESP;
          cnt <= '0;
        end
        RESP: if (data_rvalid_i) begin
          state <= IDLE;
          if (!we_q) lsu_data_o <= ld;
        end else if (timeout) state <= IDLE;
        else cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_miriscv_lsu.sv
// tb_miriscv_lsu: directed stimulus with a transaction-level reference model checked every cycle
module tb_miriscv_lsu;
  localparam int TMO = 4;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic lsu_req_i = 0, lsu_we_i = 0, data_gnt_i = 0, data_rvalid_i = 0;
  logic [2:0] lsu_size_i = 0;
  logic [31:0] lsu_addr_i = 0, lsu_data_i = 0, data_rdata_i = 0;
  logic lsu_stall_req_o, lsu_valid_o, lsu_misalign_o, lsu_bus_err_o, data_req_o, data_we_o;
  logic [31:0] lsu_data_o, data_addr_o, data_wdata_o;
  logic [3:0] data_be_o;
  int compared = 0, mismatched = 0;
  bit run = 0;

  miriscv_lsu #(.RESP_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_size_i(lsu_size_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_data_o(lsu_data_o), .lsu_valid_o(lsu_valid_o),
    .lsu_misalign_o(lsu_misalign_o), .lsu_bus_err_o(lsu_bus_err_o), .data_req_o(data_req_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] s);
    return s == 0 ? 4 : (s == 1 || s == 3) ? 2 : 1;
  endfunction
  function automatic bit legal_of(input logic [2:0] s, input logic [31:0] a);
    return s <= 4 && (a % nbytes(s)) == 0;
  endfunction
  function automatic logic [3:0] be_of(input logic [2:0] s, input logic [31:0] a);
    logic [3:0] m;
    m = nbytes(s) == 4 ? 4'hF : nbytes(s) == 2 ? 4'h3 : 4'h1;
    return m << (a % 4);
  endfunction
  function automatic logic [31:0] wdata_of(input logic [2:0] s, input logic [31:0] d);
    return nbytes(s) == 4 ? d : nbytes(s) == 2 ? (d & 32'hFFFF) * 32'h00010001 : (d & 32'hFF) * 32'h01010101;
  endfunction
  function automatic logic [31:0] load_of(input logic [2:0] s, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    v = r >> (8 * (a % 4));
    if (nbytes(s) == 2) begin
      v = v & 32'hFFFF;
      if (s == 1 && v[15]) v = v | 32'hFFFF0000;
    end else if (nbytes(s) == 1) begin
      v = v & 32'hFF;
      if (s == 2 && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  // reference model: one outstanding transaction, tracked as busy/granted/wait-count
  bit m_busy = 0, m_granted = 0, m_we = 0, e_valid = 0, e_err = 0;
  int m_wait = 0;
  logic [2:0] m_size = 0;
  logic [31:0] m_addr = 0, m_data = 0, e_data = 0;
  always @(posedge clk_i) begin
    if (rst_i) begin
      m_busy <= 0; m_granted <= 0; m_wait <= 0; e_valid <= 0; e_err <= 0; e_data <= 0;
    end else begin
      e_valid <= 0;
      e_err <= 0;
      if (!m_busy) begin
        if (lsu_req_i && legal_of(lsu_size_i, lsu_addr_i)) begin
          m_busy <= 1; m_granted <= 0;
          m_we <= lsu_we_i; m_size <= lsu_size_i; m_addr <= lsu_addr_i; m_data <= lsu_data_i;
        end
      end else if (!m_granted) begin
        if (data_gnt_i) begin m_granted <= 1; m_wait <= 0; end
      end else if (data_rvalid_i) begin
        m_busy <= 0; e_valid <= 1;
        if (!m_we) e_data <= load_of(m_size, m_addr, data_rdata_i);
      end else if (m_wait + 1 >= TMO) begin
        m_busy <= 0; e_err <= 1;
      end else m_wait <= m_wait + 1;
    end
  end

  bit lg, in_req;
  always @(negedge clk_i) if (run) begin
    lg = legal_of(lsu_size_i, lsu_addr_i);
    in_req = m_busy && !m_granted;
    chk("stall", lsu_stall_req_o, (!m_busy && lsu_req_i && lg) || in_req ||
        (m_busy && m_granted && !data_rvalid_i && m_wait + 1 < TMO));
    chk("misalign", lsu_misalign_o, !m_busy && lsu_req_i && !lg);
    chk("data_req", data_req_o, in_req);
    chk("valid", lsu_valid_o, e_valid);
    chk("bus_err", lsu_bus_err_o, e_err);
    chk("lsu_data", lsu_data_o, e_data);
    if (in_req) begin
      chk("we", data_we_o, m_we);
      chk("be", data_be_o, be_of(m_size, m_addr));
      chk("addr", data_addr_o, m_addr & ~32'h3);
      chk("wdata", data_wdata_o, wdata_of(m_size, m_data));
    end
  end

  task automatic tick; @(posedge clk_i); #1; endtask
  task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    lsu_req_i = 1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = a; lsu_data_i = d;
    tick;
    lsu_req_i = 0;
  endtask
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input int gd, input int rd, input logic [31:0] r);
    issue(we, sz, a, d);
    repeat (gd) tick;
    data_gnt_i = 1; tick; data_gnt_i = 0;
    repeat (rd) tick;
    data_rvalid_i = 1; data_rdata_i = r; tick;
    data_rvalid_i = 0; data_rdata_i = 0;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_stall"}, lsu_stall_req_o, 0); chk({tag, "_valid"}, lsu_valid_o, 0);
    chk({tag, "_err"}, lsu_bus_err_o, 0); chk({tag, "_data"}, lsu_data_o, 0);
    chk({tag, "_req"}, data_req_o, 0); chk({tag, "_we"}, data_we_o, 0);
    chk({tag, "_be"}, data_be_o, 0); chk({tag, "_addr"}, data_addr_o, 0);
    chk({tag, "_wdata"}, data_wdata_o, 0); chk({tag, "_mis"}, lsu_misalign_o, 0);
  endtask

  int held;
  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    @(negedge clk_i) all_zero("rst");
    run = 1;
    tick;
    // lb 0x1003
    lsu_req_i = 1; lsu_we_i = 0; lsu_size_i = 2; lsu_addr_i = 32'h1003;
    @(negedge clk_i) chk("lb_stall_n", lsu_stall_req_o, 1);
    tick; lsu_req_i = 0; data_gnt_i = 1;
    @(negedge clk_i) begin chk("lb_req", data_req_o, 1); chk("lb_be", data_be_o, 4'b1000); chk("lb_addr", data_addr_o, 32'h1000); end
    tick; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h8000_0000;
    @(negedge clk_i) chk("lb_valid_n2", lsu_valid_o, 0);
    tick; data_rvalid_i = 0;
    @(negedge clk_i) begin chk("lb_valid_n3", lsu_valid_o, 1); chk("lb_data", lsu_data_o, 32'hFFFFFF80); end
    tick;
    @(negedge clk_i) chk("lb_valid_n4", lsu_valid_o, 0);
    // sh 0x2002
    issue(1, 1, 32'h2002, 32'h0000ABCD);
    @(negedge clk_i) begin chk("sh_wdata", data_wdata_o, 32'hABCDABCD); chk("sh_be", data_be_o, 4'b1100); chk("sh_we", data_we_o, 1); end
    data_gnt_i = 1; tick; data_gnt_i = 0; data_rvalid_i = 1; tick; data_rvalid_i = 0;
    @(negedge clk_i) begin chk("sh_valid", lsu_valid_o, 1); chk("sh_data_kept", lsu_data_o, 32'hFFFFFF80); end
    // misaligned / illegal requests
    lsu_req_i = 1; lsu_size_i = 0; lsu_addr_i = 32'h3001;
    @(negedge clk_i) begin chk("lw_mis", lsu_misalign_o, 1); chk("lw_mis_stall", lsu_stall_req_o, 0); chk("lw_mis_req", data_req_o, 0); end
    tick;
    @(negedge clk_i) chk("lw_mis_req2", data_req_o, 0);
    lsu_size_i = 5; lsu_addr_i = 32'h3000;
    @(negedge clk_i) chk("size5_mis", lsu_misalign_o, 1);
    lsu_size_i = 3; lsu_addr_i = 32'h7001;
    @(negedge clk_i) chk("lhu_mis", lsu_misalign_o, 1);
    tick; lsu_req_i = 0;
    // grant held off 10 cycles, address input changes, stray rvalid in REQ
    issue(0, 0, 32'h4000, 0);
    lsu_addr_i = 32'hDEAD0000;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      data_rvalid_i = (i == 4);
      @(negedge clk_i) if (data_req_o && lsu_stall_req_o && data_addr_o == 32'h4000) held++;
      tick;
    end
    data_rvalid_i = 0;
    chk("gnt_wait_held", held, 10);
    data_gnt_i = 1; tick; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h12345678; tick;
    data_rvalid_i = 0;
    @(negedge clk_i) chk("gnt_wait_data", lsu_data_o, 32'h12345678);
    // response timeout
    issue(0, 0, 32'h5000, 0);
    data_gnt_i = 1; tick; data_gnt_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i) chk("tmo_stall", lsu_stall_req_o, i < 3);
      tick;
    end
    @(negedge clk_i) begin chk("tmo_err", lsu_bus_err_o, 1); chk("tmo_stall_off", lsu_stall_req_o, 0); chk("tmo_valid", lsu_valid_o, 0); end
    data_rvalid_i = 1; tick; data_rvalid_i = 0;
    @(negedge clk_i) begin chk("tmo_err_pulse", lsu_bus_err_o, 0); chk("late_valid", lsu_valid_o, 0); end
    // rvalid exactly on the threshold cycle
    access(0, 0, 32'h5004, 0, 0, 3, 32'hCAFEF00D);
    @(negedge clk_i) begin chk("thr_valid", lsu_valid_o, 1); chk("thr_err", lsu_bus_err_o, 0); chk("thr_data", lsu_data_o, 32'hCAFEF00D); end
    // reset in RESP with rvalid one cycle later
    issue(0, 0, 32'h6000, 0);
    data_gnt_i = 1; tick; data_gnt_i = 0;
    rst_i = 1; tick; rst_i = 0;
    data_rvalid_i = 1; data_rdata_i = 32'hFFFFFFFF;
    @(negedge clk_i) all_zero("rst_resp");
    tick; data_rvalid_i = 0; data_rdata_i = 0;
    @(negedge clk_i) begin chk("rst_no_valid", lsu_valid_o, 0); chk("rst_data", lsu_data_o, 0); end
    // extension cases
    access(0, 1, 32'h5002, 0, 0, 0, 32'h8001_0000);
    @(negedge clk_i) chk("lh_data", lsu_data_o, 32'hFFFF8001);
    access(0, 3, 32'h5002, 0, 1, 1, 32'h8001_0000);
    @(negedge clk_i) chk("lhu_data", lsu_data_o, 32'h00008001);
    access(0, 4, 32'h5001, 0, 0, 0, 32'h0000FF00);
    @(negedge clk_i) chk("lbu_data", lsu_data_o, 32'h000000FF);
    access(0, 2, 32'h5000, 0, 2, 0, 32'h0000007F);
    @(negedge clk_i) chk("lb_pos_data", lsu_data_o, 32'h0000007F);
    issue(1, 2, 32'h6001, 32'h1234565A);
    @(negedge clk_i) begin chk("sb_wdata", data_wdata_o, 32'h5A5A5A5A); chk("sb_be", data_be_o, 4'b0010); end
    data_gnt_i = 1; tick; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'hFFFFFFFF; tick;
    data_rvalid_i = 0;
    @(negedge clk_i) chk("sb_data_kept", lsu_data_o, 32'h0000007F);
    access(1, 0, 32'h7000, 32'h11223344, 0, 1, 0);
    tick; tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
